pc_redirect_unit: RTL and testbench

- Decides the next-PC source for the fetch stage of the 16-bit pipeline and supplies its targets.
- Consumes decoded control-flow information from the decode stage (jump, call, return, branch).
- Drives the fetch stage's PCsrc select, the three target buses and a flush.
- Holds a circular return-address stack (RAS) for call/return, plus a squash counter that ignores wrong-path decode slots after a redirect.

---
 rtl/pc_redirect_unit.sv | 187 ++++++++++++++++++
 tb/tb_pc_redirect_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Chooses the next-PC source for the fetch stage and supplies the jump,
//   branch and return targets. It keeps a circular return-address stack for
//   call/ret. After each redirect, a squash counter ignores the wrong-path
//   decode slots.
//
// Parameters
//   DEPTH          RAS entries (power of 2, 2..16)
//   SQUASH_CYCLES  decode slots ignored after each redirect (0..3)
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   dec_valid         decode slot holds a real instruction
//   dec_kind          000 none, 001 jmp, 010 call, 011 ret, 100 branch
//   dec_pc            address of the decoded instruction
//   dec_imm_j         absolute jump/call target
//   dec_imm_i         sign-extended branch byte offset
//   branch_taken      branch condition result
//   ret_fallback      return address used when the RAS is empty
//   clear_flags       synchronous clear of the sticky flags
//   PCsrc             00 PC+2, 01 J target, 10 I target, 11 return address
//   J_TypeImmediate   jump/call target
//   I_TypeImmediate   branch target (dec_pc + dec_imm_i)
//   ReturnAddress     RAS top, or ret_fallback when the stack is empty
//   flush             kill the instruction currently in fetch
//   ras_count         valid RAS entries (0..DEPTH)
//   ras_overflow      sticky: push while full
//   ras_underflow     sticky: ret while empty
//
// Optional build macro PC_REDIRECT_PERF_CNT_EN adds redirect_count, a
// saturating 16-bit count of flush cycles that clear_flags resets.
module pc_redirect_unit #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SQUASH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    input  logic [2:0]  dec_kind,
    input  logic [15:0] dec_pc,
    input  logic [15:0] dec_imm_j,
    input  logic [15:0] dec_imm_i,
    input  logic        branch_taken,
    input  logic [15:0] ret_fallback,
    input  logic        clear_flags,
    output logic [1:0]  PCsrc,
    output logic [15:0] J_TypeImmediate,
    output logic [15:0] I_TypeImmediate,
    output logic [15:0] ReturnAddress,
    output logic        flush,
    output logic [4:0]  ras_count,
    output logic        ras_overflow,
`ifdef PC_REDIRECT_PERF_CNT_EN
    output logic        ras_underflow,
    output logic [15:0] redirect_count
`else
    output logic        ras_underflow
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic {RUN, SQUASH} state_t;
    typedef enum logic [2:0] {
        K_NONE = 3'b000,
        K_JMP  = 3'b001,
        K_CALL = 3'b010,
        K_RET  = 3'b011,
        K_BR   = 3'b100
    } kind_t;

    state_t        state_q, state_d;
    logic [1:0]    sq_cnt_q, sq_cnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [4:0]    ras_count_q, ras_count_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic [15:0]   ras_mem [DEPTH];

    logic          act, push, pop, ras_full, ras_empty;
    logic [15:0]   ras_top, push_addr;

    always_comb begin
        PCsrc           = 2'b00;
        flush           = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        act             = rst_n & dec_valid & (state_q == RUN);
        ras_full        = (ras_count_q == 5'(DEPTH));
        ras_empty       = (ras_count_q == '0);
        ras_top         = ras_mem[ptr_q - PW'(1)];
        push_addr       = dec_pc + 16'd2;

        // Targets read 0 while reset is held.
        J_TypeImmediate = rst_n ? dec_imm_j : '0;
        I_TypeImmediate = rst_n ? (dec_pc + dec_imm_i) : '0;
        ReturnAddress   = !rst_n ? '0 : (ras_empty ? ret_fallback : ras_top);

        if (act) begin
            case (kind_t'(dec_kind))
                K_JMP:  begin PCsrc = 2'b01; flush = 1'b1; end
                K_CALL: begin PCsrc = 2'b01; flush = 1'b1; push = 1'b1; end
                K_RET:  begin PCsrc = 2'b11; flush = 1'b1; pop  = 1'b1; end
                K_BR:   if (branch_taken) begin PCsrc = 2'b10; flush = 1'b1; end
                default: ;
            endcase
        end

        ptr_d       = ptr_q;
        ras_count_d = ras_count_q;
        ovf_d       = ovf_q & ~clear_flags;
        unf_d       = unf_q & ~clear_flags;

        // A push onto a full stack wraps the pointer onto the oldest entry.
        if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (ras_full) ovf_d = 1'b1;
            else          ras_count_d = ras_count_q + 5'd1;
        end
        if (pop) begin
            if (ras_empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d       = ptr_q - PW'(1);
                ras_count_d = ras_count_q - 5'd1;
            end
        end

        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        case (state_q)
            RUN: if (flush && SQUASH_CYCLES != 0) begin
                state_d  = SQUASH;
                sq_cnt_d = 2'(SQUASH_CYCLES);
            end
            SQUASH: begin
                sq_cnt_d = sq_cnt_q - 2'd1;
                if (sq_cnt_q <= 2'd1) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            sq_cnt_q    <= '0;
            ptr_q       <= '0;
            ras_count_q <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sq_cnt_q    <= sq_cnt_d;
            ptr_q       <= ptr_d;
            ras_count_q <= ras_count_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Stack storage needs no reset: ras_count=0 masks stale entries.
    always_ff @(posedge clk) begin
        if (push) ras_mem[ptr_q] <= push_addr;
    end

    assign ras_count     = ras_count_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

`ifdef PC_REDIRECT_PERF_CNT_EN
    logic [15:0] rc_q, rc_d;

    always_comb begin
        rc_d = rc_q;
        if (flush) rc_d = clear_flags ? 16'd1 : ((rc_q == '1) ? rc_q : rc_q + 16'd1);
        else if (clear_flags) rc_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rc_q <= '0;
        else        rc_q <= rc_d;
    end

    assign redirect_count = rc_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SQ    = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid = 1'b0;
    logic [2:0]  dec_kind = '0;
    logic [15:0] dec_pc = '0, dec_imm_j = '0, dec_imm_i = '0, ret_fallback = '0;
    logic        branch_taken = 1'b0, clear_flags = 1'b0;
    logic [1:0]  PCsrc;
    logic [15:0] J_TypeImmediate, I_TypeImmediate, ReturnAddress;
    logic        flush, ras_overflow, ras_underflow;
    logic [4:0]  ras_count;
`ifdef PC_REDIRECT_PERF_CNT_EN
    logic [15:0] redirect_count;
    int unsigned m_rc = 0;
`endif

    always #5 clk = ~clk;

    pc_redirect_unit #(.DEPTH(DEPTH), .SQUASH_CYCLES(SQ)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_kind(dec_kind),
        .dec_pc(dec_pc), .dec_imm_j(dec_imm_j), .dec_imm_i(dec_imm_i),
        .branch_taken(branch_taken), .ret_fallback(ret_fallback),
        .clear_flags(clear_flags), .PCsrc(PCsrc),
        .J_TypeImmediate(J_TypeImmediate), .I_TypeImmediate(I_TypeImmediate),
        .ReturnAddress(ReturnAddress), .flush(flush), .ras_count(ras_count),
        .ras_overflow(ras_overflow),
`ifdef PC_REDIRECT_PERF_CNT_EN
        .ras_underflow(ras_underflow), .redirect_count(redirect_count)
`else
        .ras_underflow(ras_underflow)
`endif
    );

    typedef struct {
        logic [1:0]  pcsrc;
        logic [15:0] j, i, r;
        logic        fl;
        logic [4:0]  cnt;
        logic        ovf, unf;
        logic [15:0] rc;
    } exp_t;

    exp_t        sb[$];
    int          ntests = 0;
    int          nfail  = 0;

    // Reference model: return stack as a bounded list, newest at the back.
    logic [15:0] stk[$];
    bit          m_ovf = 0, m_unf = 0;
    int          m_sq = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One decode slot: drive at negedge, predict, push to scoreboard, advance model.
    task automatic slot(input bit rn, input bit v, input int k, input logic [15:0] pc,
                        input logic [15:0] ij, input logic [15:0] ii, input bit tk,
                        input logic [15:0] fb, input bit clr);
        exp_t e;
        bit   a, redir;
        int   kk;
        @(negedge clk);
        rst_n = rn; dec_valid = v; dec_kind = 3'(k); dec_pc = pc; dec_imm_j = ij;
        dec_imm_i = ii; branch_taken = tk; ret_fallback = fb; clear_flags = clr;
        if (!rn) begin
            stk.delete(); m_ovf = 0; m_unf = 0; m_sq = 0;
`ifdef PC_REDIRECT_PERF_CNT_EN
            m_rc = 0;
`endif
            e = '{pcsrc: 2'b00, j: 16'h0, i: 16'h0, r: 16'h0, fl: 1'b0,
                  cnt: 5'd0, ovf: 1'b0, unf: 1'b0, rc: 16'h0};
            sb.push_back(e);
            return;
        end
        kk = (k > 4) ? 0 : k;
        a  = v && (m_sq == 0);
        e.j   = ij;
        e.i   = pc + ii;
        e.r   = (stk.size() > 0) ? stk[$] : fb;
        e.cnt = 5'(stk.size());
        e.ovf = m_ovf;
        e.unf = m_unf;
`ifdef PC_REDIRECT_PERF_CNT_EN
        e.rc  = 16'(m_rc);
`else
        e.rc  = 16'h0;
`endif
        e.pcsrc = 2'b00;
        if (a) begin
            if (kk == 1 || kk == 2) e.pcsrc = 2'b01;
            else if (kk == 3)       e.pcsrc = 2'b11;
            else if (kk == 4 && tk) e.pcsrc = 2'b10;
        end
        redir = (e.pcsrc != 2'b00);
        e.fl  = redir;
        sb.push_back(e);

        if (clr) begin m_ovf = 0; m_unf = 0; end
        if (a && kk == 2) begin
            if (stk.size() == DEPTH) begin void'(stk.pop_front()); m_ovf = 1; end
            stk.push_back(pc + 16'd2);
        end
        if (a && kk == 3) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else m_unf = 1;
        end
        if (m_sq > 0) m_sq--;
        else if (redir && SQ > 0) m_sq = SQ;
`ifdef PC_REDIRECT_PERF_CNT_EN
        if (redir) m_rc = clr ? 1 : ((m_rc < 65535) ? m_rc + 1 : m_rc);
        else if (clr) m_rc = 0;
`endif
    endtask

    task automatic op(input int k, input logic [15:0] pc, input logic [15:0] ij,
                      input logic [15:0] ii, input bit tk, input logic [15:0] fb);
        slot(1, 1, k, pc, ij, ii, tk, fb, 0);
    endtask

    task automatic idle(input bit clr);
        slot(1, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0, clr);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-low-phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("PCsrc", 16'(PCsrc), 16'(e.pcsrc));
                chk("flush", 16'(flush), 16'(e.fl));
                chk("J_TypeImmediate", J_TypeImmediate, e.j);
                chk("I_TypeImmediate", I_TypeImmediate, e.i);
                chk("ReturnAddress", ReturnAddress, e.r);
                chk("ras_count", 16'(ras_count), 16'(e.cnt));
                chk("ras_overflow", 16'(ras_overflow), 16'(e.ovf));
                chk("ras_underflow", 16'(ras_underflow), 16'(e.unf));
`ifdef PC_REDIRECT_PERF_CNT_EN
                chk("redirect_count", redirect_count, e.rc);
`endif
            end
        end
    end

    initial begin
        slot(0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0, 0);
        slot(0, 1, 1, 16'h1234, 16'h5678, 16'h9, 1, 16'h0, 0);

        // Call, squashed jmp, return.
        op(2, 16'h0010, 16'h0100, 16'h0, 0, 16'h0);
        op(1, 16'h0030, 16'h0200, 16'h0, 0, 16'h0);
        op(3, 16'h0100, 16'h0, 16'h0, 0, 16'h0);
        idle(0);

        // Empty-stack return, then clear.
        op(3, 16'h0200, 16'h0, 16'h0, 0, 16'h0ABC);
        idle(0);
        idle(1);
        idle(0);

        // Overflow and unwind.
        for (int n = 0; n < 5; n++) begin
            op(2, 16'(n * 16), 16'h0400, 16'h0, 0, 16'h0);
            idle(0);
        end
        for (int n = 0; n < 5; n++) begin
            op(3, 16'h0400, 16'h0, 16'h0, 0, 16'h0BAD);
            idle(0);
        end
        idle(1);

        // Branches.
        op(4, 16'h0020, 16'h0, 16'h0040, 0, 16'h0);
        op(4, 16'h0020, 16'h0, 16'hFFF0, 1, 16'h0);
        idle(0);
        op(4, 16'hFFFE, 16'h0, 16'h0004, 1, 16'h0);
        idle(0);

        // Reset during SQUASH with two entries, then immediate jmp.
        op(2, 16'h0100, 16'h0800, 16'h0, 0, 16'h0);
        idle(0);
        op(2, 16'h0200, 16'h0800, 16'h0, 0, 16'h0);
        op(0, 16'h0, 16'h0, 16'h0, 0, 16'h0);
        op(1, 16'h0300, 16'h0900, 16'h0, 0, 16'h0);
        slot(0, 1, 1, 16'h0300, 16'h0900, 16'h0, 0, 16'h0, 0);
        op(1, 16'h0040, 16'h0A00, 16'h0, 0, 16'h0);
        idle(0);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            bit rn, v, tk, clr;
            rn  = ($urandom_range(0, 99) >= 2);
            v   = ($urandom_range(0, 99) < 85);
            tk  = $urandom_range(0, 1) != 0;
            clr = ($urandom_range(0, 99) < 8);
            slot(rn, v, int'($urandom_range(0, 7)), 16'($urandom) & 16'hFFFE,
                 16'($urandom), 16'($urandom), tk, 16'($urandom), clr);
        end

        idle(0);
        for (int n = 0; n < 10 && sb.size() != 0; n++) @(negedge clk);
        #4;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
